// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared types and constants for the render queue loader
package render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VB,
        ST_CLEAR,
        ST_STREAM,
        ST_ENDM
    } rql_state_t;

    localparam logic [1:0] ADDR_ENTRY  = 2'd0;
    localparam logic [1:0] ADDR_COMMIT = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CLRSTS = 2'd3;

    localparam logic [7:0] END_MARKER_DEF = 8'hFF;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] flags;
    } rq_entry_t;

endpackage

// File: rtl/rq_stage_ram.sv
// rtl/rq_stage_ram.sv - DEPTH x 32 simple dual-port staging RAM, registered read
module rq_stage_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Output register holds between reads so the serializer can pick bytes from it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/render_queue_loader.sv
// rtl/render_queue_loader.sv - Avalon staging buffer that flushes sprite entries into the render queue
// Optional VBLANK_SYNC_EN: hold the flush until vertical blanking.
module render_queue_loader
    import render_pkg::*;
#(
    parameter int         DEPTH      = 64,
    parameter logic [7:0] END_MARKER = END_MARKER_DEF
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        vblank,
    output logic        clear_render_queue,
    output logic        render_queue_we,
    output logic [7:0]  render_queue_din
);

    localparam int AW = $clog2(DEPTH);

    rql_state_t  state, state_nxt;
    logic [8:0]  count;
    logic [8:0]  n_latched;
    logic [8:0]  entry_idx;
    logic [1:0]  byte_idx;
    logic        overflow;
    logic        late;
    logic [7:0]  din_hold;
    logic [31:0] rd_data;
    rq_entry_t   cur_e;
    logic [7:0]  stream_byte;
    logic        vb_ok;

    logic busy, wr_en, entry_wr, entry_ok, commit_wr, commit_go, clrsts_wr, last_byte;
    logic ram_re;
    logic [AW-1:0] ram_raddr;

    assign busy      = (state != ST_IDLE);
    assign wr_en     = chipselect & write;
    assign entry_wr  = wr_en && (address == ADDR_ENTRY);
    assign entry_ok  = entry_wr && !busy && (count != 9'(DEPTH));
    assign commit_wr = wr_en && (address == ADDR_COMMIT);
    assign commit_go = commit_wr && !busy && (count != 9'd0);
    assign clrsts_wr = wr_en && (address == ADDR_CLRSTS);
    assign last_byte = (state == ST_STREAM) && (byte_idx == 2'd3) && (entry_idx == n_latched - 9'd1);

`ifdef VBLANK_SYNC_EN
    assign vb_ok = vblank;
`else
    // Without blanking sync the wait is a single cycle; vblank has no effect.
    assign vb_ok = 1'b1 | vblank;
`endif

    always_ff @(posedge clk50) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (commit_go) state_nxt = ST_WAIT_VB;
            ST_WAIT_VB: if (vb_ok) state_nxt = ST_CLEAR;
            ST_CLEAR:   state_nxt = ST_STREAM;
            ST_STREAM:  if (last_byte) state_nxt = ST_ENDM;
            ST_ENDM:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Next entry is fetched on the last byte of the current one, so the RAM output
    // register always holds the entry being serialized.
    assign ram_re    = (state == ST_CLEAR) || ((state == ST_STREAM) && (byte_idx == 2'd3));
    assign ram_raddr = (state == ST_CLEAR) ? '0 : entry_idx[AW-1:0] + AW'(1);

    rq_stage_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk50),
        .we    (entry_ok),
        .waddr (count[AW-1:0]),
        .wdata (writedata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );

    assign cur_e = rq_entry_t'(rd_data);

    always_comb begin
        stream_byte = cur_e.id;
        case (byte_idx)
            2'd0: stream_byte = cur_e.id;
            2'd1: stream_byte = cur_e.x;
            2'd2: stream_byte = cur_e.y;
            2'd3: stream_byte = cur_e.flags;
            default: stream_byte = cur_e.id;
        endcase
    end

    assign clear_render_queue = (state == ST_CLEAR);
    assign render_queue_we    = (state == ST_STREAM) || (state == ST_ENDM);
    assign render_queue_din   = (state == ST_STREAM) ? stream_byte :
                                (state == ST_ENDM)   ? END_MARKER  : din_hold;

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            count     <= '0;
            n_latched <= '0;
            entry_idx <= '0;
            byte_idx  <= '0;
            overflow  <= 1'b0;
            late      <= 1'b0;
            din_hold  <= '0;
            readdata  <= '0;
        end else begin
            readdata <= (chipselect && read && address == ADDR_STATUS) ?
                        {16'h0, count[7:0], 5'h0, late, overflow, busy} : 32'h0;
            if (entry_wr) begin
                if (entry_ok) count <= count + 9'd1;
                else          overflow <= 1'b1;
            end
            if (commit_wr && busy) late <= 1'b1;
            if (clrsts_wr) begin
                if (writedata[0]) overflow <= 1'b0;
                if (writedata[1]) late <= 1'b0;
            end
            if (commit_go) n_latched <= count;
            if (state == ST_CLEAR) begin
                entry_idx <= '0;
                byte_idx  <= '0;
            end
            if (state == ST_STREAM) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) entry_idx <= entry_idx + 9'd1;
            end
            if (state == ST_ENDM) count <= '0;
            if (render_queue_we) din_hold <= render_queue_din;
        end
    end

endmodule

// File: tb/tb_render_queue_loader.sv
// tb/tb_render_queue_loader.sv - self-checking bench for render_queue_loader
module tb_render_queue_loader;

    localparam int DEPTH = 64;
`ifdef VBLANK_SYNC_EN
    localparam bit VB_MODE = 1'b1;
`else
    localparam bit VB_MODE = 1'b0;
`endif

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        vblank = 1'b1;
    logic        clear_render_queue;
    logic        render_queue_we;
    logic [7:0]  render_queue_din;

    always #5 clk50 = ~clk50;

    render_queue_loader #(.DEPTH(DEPTH)) dut (
        .clk50              (clk50),
        .reset_n            (reset_n),
        .chipselect         (chipselect),
        .write              (write),
        .read               (read),
        .address            (address),
        .writedata          (writedata),
        .readdata           (readdata),
        .vblank             (vblank),
        .clear_render_queue (clear_render_queue),
        .render_queue_we    (render_queue_we),
        .render_queue_din   (render_queue_din)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: expected output per cycle, built as a schedule when a commit is accepted.
    typedef struct {
        bit         clr;
        bit         we;
        logic [7:0] din;
        bit         busy;
        bit         wait_vb;
        bit         endm;
    } exp_t;

    function automatic exp_t mk(bit clr, bit we, logic [7:0] din, bit busy, bit wvb, bit endm);
        exp_t e;
        e.clr = clr; e.we = we; e.din = din; e.busy = busy; e.wait_vb = wvb; e.endm = endm;
        return e;
    endfunction

    exp_t        sched[$];
    exp_t        cur = mk(0, 0, 8'h00, 0, 0, 0);
    logic [31:0] ent[$];
    bit          m_ov = 0, m_late = 0;
    bit          rd_chk = 0;
    logic [31:0] rd_exp = 32'h0;
    int          cyc = 0;
    int          commit_edge = -1;

    always @(posedge clk50) begin
        bit busy;
        logic [31:0] w;
        cyc++;
        if (!reset_n) begin
            sched.delete();
            ent.delete();
            m_ov = 0; m_late = 0;
            cur = mk(0, 0, 8'h00, 0, 0, 0);
            rd_chk = 1; rd_exp = 32'h0;
        end else begin
            busy   = cur.busy;
            rd_chk = chipselect && read;
            rd_exp = (rd_chk && address == 2'd2) ?
                     {16'h0, 8'(ent.size()), 5'h0, m_late, m_ov, busy} : 32'h0;
            if (chipselect && write) begin
                case (address)
                    2'd0: if (busy || ent.size() == DEPTH) m_ov = 1; else ent.push_back(writedata);
                    2'd1: begin
                        if (busy) m_late = 1;
                        else if (ent.size() > 0) begin
                            commit_edge = cyc;
                            sched.push_back(mk(0, 0, 8'h00, 1, 1, 0));
                            sched.push_back(mk(1, 0, 8'h00, 1, 0, 0));
                            foreach (ent[i]) begin
                                w = ent[i];
                                for (int b = 0; b < 4; b++)
                                    sched.push_back(mk(0, 1, w[31-8*b -: 8], 1, 0, 0));
                            end
                            sched.push_back(mk(0, 1, 8'hFF, 1, 0, 1));
                        end
                    end
                    2'd3: begin
                        if (writedata[0]) m_ov = 0;
                        if (writedata[1]) m_late = 0;
                    end
                    default: ;
                endcase
            end
            if (cur.endm) ent.delete();
            if (!(cur.wait_vb && VB_MODE && !vblank))
                cur = (sched.size() > 0) ? sched.pop_front() : mk(0, 0, 8'h00, 0, 0, 0);
        end
    end

    logic [7:0] obs[$];
    int         obs_cyc[$];
    int         clr_cnt = 0;
    int         clr_cyc = -1;

    always @(negedge clk50) begin
        if (cyc > 0) begin
            chk("clear", 32'(clear_render_queue), 32'(cur.clr));
            chk("we", 32'(render_queue_we), 32'(cur.we));
            if (cur.we) chk("din", 32'(render_queue_din), 32'(cur.din));
            if (rd_chk) chk("readdata", readdata, rd_exp);
            if (render_queue_we) begin
                obs.push_back(render_queue_din);
                obs_cyc.push_back(cyc);
            end
            if (clear_render_queue) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
        end
    end

    task automatic bus(input bit w, input bit r, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk50);
        chipselect = w | r; write = w; read = r; address = a; writedata = d;
    endtask

    task automatic bus_idle();
        bus(0, 0, 2'd0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1, 0, a, d);
        bus_idle();
    endtask

    task automatic rd_status(output logic [31:0] v);
        bus(0, 1, 2'd2, 32'h0);
        bus_idle();
        v = readdata;
    endtask

    logic [7:0]  exp2 [9] = '{8'h01, 8'h10, 8'h20, 8'h00, 8'h02, 8'h30, 8'h40, 8'h01, 8'hFF};
    logic [31:0] st;
    int          n0, c0, vb_cyc;

    initial begin
        // Reset held three cycles
        reset_n = 1'b0;
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;
        rd_status(st);
        chk("t1_status", st, 32'h0);

        // Two entries, then commit
        obs.delete(); obs_cyc.delete();
        wr(2'd0, 32'h01102000);
        wr(2'd0, 32'h02304001);
        wr(2'd1, 32'h0);
        repeat (14) @(negedge clk50);
        chk("t2_nbytes", 32'(obs.size()), 32'd9);
        for (int i = 0; i < 9 && i < obs.size(); i++) chk("t2_byte", 32'(obs[i]), 32'(exp2[i]));
        chk("t2_clear_lat", 32'(clr_cyc - commit_edge), 32'd1);
        if (obs_cyc.size() == 9) begin
            chk("t2_first_we", 32'(obs_cyc[0] - commit_edge), 32'd2);
            chk("t2_endm", 32'(obs_cyc[8] - commit_edge), 32'd10);
        end
        rd_status(st);
        chk("t2_status", st, 32'h0);

        // DEPTH+1 back-to-back entries
        for (int i = 0; i <= DEPTH; i++) bus(1, 0, 2'd0, 32'(i) * 32'h01030507 + 32'h11);
        bus_idle();
        rd_status(st);
        chk("t3_status_ovf", st, 32'h00004002);
        wr(2'd3, 32'h1);
        rd_status(st);
        chk("t3_status_clr", st, 32'h00004000);

        // Commit during stream, then empty commit
        obs.delete(); obs_cyc.delete();
        wr(2'd1, 32'h0);
        repeat (20) @(negedge clk50);
        wr(2'd1, 32'h0);
        repeat (280) @(negedge clk50);
        chk("t4_nbytes", 32'(obs.size()), 32'd257);
        rd_status(st);
        chk("t4_status_late", st, 32'h00000004);
        wr(2'd3, 32'h2);
        rd_status(st);
        chk("t4_status_clr", st, 32'h0);
        n0 = obs.size(); c0 = clr_cnt;
        wr(2'd1, 32'h0);
        repeat (10) @(negedge clk50);
        chk("t4_empty_clear", 32'(clr_cnt), 32'(c0));
        chk("t4_empty_we", 32'(obs.size()), 32'(n0));

`ifdef VBLANK_SYNC_EN
        // Flush held until blanking
        vblank = 1'b0;
        c0 = clr_cnt;
        wr(2'd0, 32'h0A0B0C0D);
        wr(2'd1, 32'h0);
        repeat (100) @(negedge clk50);
        chk("t5_no_clear", 32'(clr_cnt), 32'(c0));
        vblank = 1'b1;
        vb_cyc = cyc;
        repeat (12) @(negedge clk50);
        chk("t5_clear_lat", 32'(clr_cyc - vb_cyc), 32'd1);
`endif

        // Reset on the third streamed byte
        obs.delete(); obs_cyc.delete();
        wr(2'd0, 32'hAABBCCDD);
        wr(2'd0, 32'h11223344);
        bus(1, 0, 2'd1, 32'h0);
        bus_idle();
        repeat (4) @(negedge clk50);
        reset_n = 1'b0;
        @(negedge clk50);
        reset_n = 1'b1;
        repeat (12) @(negedge clk50);
        chk("t6_nbytes", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) chk("t6_last", 32'(obs[2]), 32'hCC);
        rd_status(st);
        chk("t6_status", st, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
